// File: rtl/sb_pkg.sv
// Shared sideband constants, byte-FSM state type and the CRC-16 (0x8005) byte update.
package sb_pkg;
    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;

    localparam logic [2:0] ERR_FRAME = 3'd1;
    localparam logic [2:0] ERR_CLSE  = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;
    localparam logic [2:0] ERR_CTRL  = 3'd5;
    localparam logic [2:0] ERR_TMO   = 3'd6;

    typedef enum logic [2:0] {
        HUNT, GOT_DLE, LT_CLSE, LT_DLE, LT_ETX, AT_DATA, AT_DLE
    } byte_state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
endpackage

// File: rtl/sb_rx_deframer_if.sv
// Line input, enable and result bus between the sideband deframer and its logical-layer consumers.
interface sb_rx_deframer_if #(parameter int MAX_AT_BYTES = 16);
    localparam int LEN_W = $clog2(MAX_AT_BYTES + 1);

    logic                      sb_en;
    logic                      sbrx;
    logic                      lt_valid;
    logic [7:0]                lt_lse;
    logic                      at_valid;
    logic                      at_is_rsp;
    logic [LEN_W-1:0]          at_len;
    logic [8*MAX_AT_BYTES-1:0] at_data;
    logic                      err_valid;
    logic [2:0]                err_code;

    modport master (input sb_en, sbrx,
                    output lt_valid, lt_lse, at_valid, at_is_rsp, at_len, at_data, err_valid, err_code);
    modport slave  (output sb_en, sbrx,
                    input lt_valid, lt_lse, at_valid, at_is_rsp, at_len, at_data, err_valid, err_code);
endinterface

// File: rtl/sb_uart_rx.sv
// Sideband symbol receiver: 2-flop synchroniser, start/8 data LSB-first/stop bit FSM, framing check.
module sb_uart_rx (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sb_en,
    input  logic       sbrx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       bit_idle,
    output logic       start_edge
);
    localparam logic [1:0] B_IDLE = 2'd0;
    localparam logic [1:0] B_DATA = 2'd1;
    localparam logic [1:0] B_WAIT = 2'd2;

    logic       sync_p0, sync_p1, line_p2;
    logic [1:0] state;
    logic [3:0] cnt;
    logic [7:0] shreg;
    logic       stop_cyc;

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
        end else begin
            sync_p0 <= sbrx;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
        end
    end

    assign bit_idle   = (state == B_IDLE);
    assign start_edge = sb_en && bit_idle && line_p2 && !sync_p1;
    assign stop_cyc   = (state == B_DATA) && (cnt == 4'd9);
    assign byte_valid = sb_en && stop_cyc && sync_p1;
    assign frame_err  = sb_en && stop_cyc && !sync_p1;
    assign rx_byte    = shreg;

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state <= B_IDLE;
            cnt   <= 4'd0;
        end else if (!sb_en) begin
            state <= B_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                B_IDLE: if (start_edge) begin
                    state <= B_DATA;
                    cnt   <= 4'd1;
                end
                B_DATA: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) state <= sync_p1 ? B_IDLE : B_WAIT;
                end
                // after a bad stop bit, a new start is only hunted once the line has returned high
                B_WAIT: if (sync_p1) state <= B_IDLE;
                default: state <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge sb_clk) begin
        if (state == B_DATA && cnt != 4'd9) shreg <= {sync_p1, shreg[7:1]};
    end
endmodule

// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer: strips DLE framing, checks LT CLSE and AT CRC-16, emits one-cycle results.
module sb_rx_deframer #(
    parameter int MAX_AT_BYTES = 16,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic             sb_clk,
    input  logic             rst,
    sb_rx_deframer_if.master bus
);
    import sb_pkg::*;

    localparam int LEN_W = $clog2(MAX_AT_BYTES + 1);
    localparam int IDX_W = $clog2(MAX_AT_BYTES);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]                rx_byte;
    logic                      byte_valid, frame_err, bit_idle, start_edge;
    byte_state_t               state, nxt;
    logic [7:0]                lse;
    logic [15:0]               crc;
    logic [LEN_W-1:0]          n_stored;
    logic                      is_rsp;
    logic [TMO_W-1:0]          tmo_cnt;
    logic [7:0]                buf_mem [MAX_AT_BYTES];
    logic                      ev_lt, ev_at, ev_err, tmo_hit, store, at_start, lse_cap;
    logic [2:0]                err_nxt;
    logic [8*MAX_AT_BYTES-1:0] at_data_nxt;

    sb_uart_rx u_rx (
        .sb_clk     (sb_clk),
        .rst        (rst),
        .sb_en      (bus.sb_en),
        .sbrx       (bus.sbrx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .bit_idle   (bit_idle),
        .start_edge (start_edge)
    );

    always_comb begin
        nxt      = state;
        ev_lt    = 1'b0;
        ev_at    = 1'b0;
        ev_err   = 1'b0;
        err_nxt  = ERR_CTRL;
        store    = 1'b0;
        at_start = 1'b0;
        lse_cap  = 1'b0;
        tmo_hit  = bus.sb_en && state != HUNT && bit_idle && !start_edge
                   && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1);
        if (frame_err) begin
            ev_err  = 1'b1;
            err_nxt = ERR_FRAME;
        end else if (tmo_hit) begin
            ev_err  = 1'b1;
            err_nxt = ERR_TMO;
        end else if (byte_valid) begin
            case (state)
                HUNT:    if (rx_byte == DLE) nxt = GOT_DLE;
                // DLE is tested first: its bit 7 is set but it never starts an LT
                GOT_DLE: if (rx_byte == DLE)      nxt = GOT_DLE;
                         else if (rx_byte[7])     begin nxt = LT_CLSE; lse_cap = 1'b1; end
                         else if (rx_byte == STX_CMD || rx_byte == STX_RSP)
                                                  begin nxt = AT_DATA; at_start = 1'b1; end
                         else                     ev_err = 1'b1;
                LT_CLSE: if (rx_byte == ~lse) nxt = LT_DLE;
                         else begin ev_err = 1'b1; err_nxt = ERR_CLSE; end
                LT_DLE:  if (rx_byte == DLE) nxt = LT_ETX; else ev_err = 1'b1;
                LT_ETX:  if (rx_byte == ETX) ev_lt = 1'b1; else ev_err = 1'b1;
                AT_DATA: if (rx_byte == DLE) nxt = AT_DLE; else store = 1'b1;
                AT_DLE:  if (rx_byte == DLE) store = 1'b1;
                         else if (rx_byte == ETX) begin
                             if (n_stored < LEN_W'(2) || crc != 16'h0000) begin
                                 ev_err  = 1'b1;
                                 err_nxt = ERR_CRC;
                             end else ev_at = 1'b1;
                         end else ev_err = 1'b1;
                default: nxt = HUNT;
            endcase
            if (store) begin
                if (n_stored == LEN_W'(MAX_AT_BYTES)) begin
                    store   = 1'b0;
                    ev_err  = 1'b1;
                    err_nxt = ERR_OVF;
                end else nxt = AT_DATA;
            end
        end
        if (ev_err || ev_lt || ev_at) nxt = HUNT;
    end

    always_comb begin
        at_data_nxt = '0;
        for (int i = 0; i < MAX_AT_BYTES; i++)
            if (i < int'(n_stored) - 2) at_data_nxt[8*i +: 8] = buf_mem[i];
    end

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            crc           <= 16'hFFFF;
            n_stored      <= '0;
            is_rsp        <= 1'b0;
            tmo_cnt       <= '0;
            bus.lt_valid  <= 1'b0;
            bus.lt_lse    <= 8'h00;
            bus.at_valid  <= 1'b0;
            bus.at_is_rsp <= 1'b0;
            bus.at_len    <= '0;
            bus.at_data   <= '0;
            bus.err_valid <= 1'b0;
            bus.err_code  <= 3'd0;
        end else begin
            bus.lt_valid  <= ev_lt;
            bus.at_valid  <= ev_at;
            bus.err_valid <= ev_err;
            state         <= bus.sb_en ? nxt : HUNT;
            if (!bus.sb_en || start_edge || state == HUNT) tmo_cnt <= '0;
            else if (bit_idle)                             tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (at_start) begin
                crc      <= crc16_byte(16'hFFFF, rx_byte);
                n_stored <= '0;
                is_rsp   <= (rx_byte == STX_RSP);
            end else if (store) begin
                crc      <= crc16_byte(crc, rx_byte);
                n_stored <= n_stored + LEN_W'(1);
            end
            if (ev_lt) bus.lt_lse <= lse;
            if (ev_at) begin
                bus.at_is_rsp <= is_rsp;
                bus.at_len    <= n_stored - LEN_W'(2);
                bus.at_data   <= at_data_nxt;
            end
            if (ev_err) bus.err_code <= err_nxt;
        end
    end

    always_ff @(posedge sb_clk) begin
        if (lse_cap) lse <= rx_byte;
        if (store)   buf_mem[n_stored[IDX_W-1:0]] <= rx_byte;
    end
endmodule

// File: tb/tb_sb_rx_deframer.sv
// Scoreboard bench for sb_rx_deframer: frames are built from their intended outcome, results checked in order.
`timescale 1ns/1ps
module tb_sb_rx_deframer;
    import sb_pkg::*;

    localparam int MAXB  = 16;
    localparam int TMO   = 64;
    localparam int LEN_W = $clog2(MAXB + 1);

    typedef logic [7:0] byteq_t[$];
    typedef struct {
        int                kind;   // 0 LT, 1 AT, 2 error
        logic [7:0]        lse;
        logic              is_rsp;
        int                len;
        logic [8*MAXB-1:0] data;
        logic [2:0]        code;
    } exp_t;

    logic   sb_clk = 1'b0;
    logic   rst;
    exp_t   expq[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    byteq_t pl;

    always #5 sb_clk = ~sb_clk;

    sb_rx_deframer_if #(.MAX_AT_BYTES(MAXB)) bus();

    sb_rx_deframer #(.MAX_AT_BYTES(MAXB), .TIMEOUT_CYC(TMO)) dut (
        .sb_clk (sb_clk),
        .rst    (rst),
        .bus    (bus)
    );

    function automatic logic [15:0] crc_ref(input byteq_t m);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (m[i]) begin
            r = r ^ {m[i], 8'h00};
            for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        return r;
    endfunction

    function automatic exp_t mk_err(input logic [2:0] code);
        exp_t e;
        e = '{kind: 2, lse: 8'h00, is_rsp: 1'b0, len: 0, data: '0, code: code};
        return e;
    endfunction

    task automatic tx_byte(input logic [7:0] b, input logic stop);
        @(negedge sb_clk) bus.sbrx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sb_clk) bus.sbrx = b[i];
        end
        @(negedge sb_clk) bus.sbrx = stop;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sb_clk) bus.sbrx = 1'b1;
        end
    endtask

    task automatic send_lt(input logic [7:0] lse, input bit bad_clse);
        exp_t e;
        if (bad_clse) e = mk_err(ERR_CLSE);
        else e = '{kind: 0, lse: lse, is_rsp: 1'b0, len: 0, data: '0, code: 3'd0};
        expq.push_back(e);
        tx_byte(DLE, 1'b1);
        tx_byte(lse, 1'b1);
        if (bad_clse) tx_byte(~lse ^ 8'h01, 1'b1);
        else begin
            tx_byte(~lse, 1'b1);
            tx_byte(DLE, 1'b1);
            tx_byte(ETX, 1'b1);
        end
    endtask

    task automatic send_at(input logic rsp, input byteq_t p, input bit bad_crc);
        byteq_t      body;
        byteq_t      w;
        logic [15:0] c;
        exp_t        e;
        body = {};
        body.push_back(rsp ? STX_RSP : STX_CMD);
        foreach (p[i]) body.push_back(p[i]);
        c = crc_ref(body);
        if (bad_crc) c[0] = ~c[0];
        foreach (p[i]) w.push_back(p[i]);
        w.push_back(c[15:8]);
        w.push_back(c[7:0]);
        if (bad_crc) e = mk_err(ERR_CRC);
        else begin
            e = '{kind: 1, lse: 8'h00, is_rsp: rsp, len: p.size(), data: '0, code: 3'd0};
            foreach (p[i]) e.data[8*i +: 8] = p[i];
        end
        expq.push_back(e);
        tx_byte(DLE, 1'b1);
        tx_byte(body[0], 1'b1);
        foreach (w[i]) begin
            tx_byte(w[i], 1'b1);
            if (w[i] == DLE) tx_byte(DLE, 1'b1);
        end
        tx_byte(DLE, 1'b1);
        tx_byte(ETX, 1'b1);
    endtask

    // Monitor: every result pulse is matched against the head of the expected queue.
    always @(negedge sb_clk) begin
        if (bus.lt_valid || bus.at_valid || bus.err_valid) begin
            checks++;
            if (int'(bus.lt_valid) + int'(bus.at_valid) + int'(bus.err_valid) != 1) begin
                errors++;
                $display("FAIL onehot: lt=%0b at=%0b err=%0b, required exactly one", bus.lt_valid, bus.at_valid, bus.err_valid);
            end
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: lt=%0b at=%0b err=%0b code=%0d, required none", bus.lt_valid, bus.at_valid, bus.err_valid, bus.err_code);
            end else begin
                mon_e = expq.pop_front();
                checks++;
                case (mon_e.kind)
                    0: if (!bus.lt_valid || bus.lt_lse != mon_e.lse) begin
                        errors++;
                        $display("FAIL lt_result: lt_valid=%0b lse=%h, required 1/%h", bus.lt_valid, bus.lt_lse, mon_e.lse);
                    end
                    1: if (!bus.at_valid || bus.at_is_rsp != mon_e.is_rsp || bus.at_len != LEN_W'(mon_e.len) || bus.at_data != mon_e.data) begin
                        errors++;
                        $display("FAIL at_result: at_valid=%0b rsp=%0b len=%0d data=%h, required 1/%0b/%0d/%h", bus.at_valid, bus.at_is_rsp, bus.at_len, bus.at_data, mon_e.is_rsp, mon_e.len, mon_e.data);
                    end
                    default: if (!bus.err_valid || bus.err_code != mon_e.code) begin
                        errors++;
                        $display("FAIL err_result: err_valid=%0b code=%0d, required 1/%0d", bus.err_valid, bus.err_code, mon_e.code);
                    end
                endcase
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.sbrx   = 1'b1;
        bus.sb_en  = 1'b1;
        repeat (3) @(negedge sb_clk);
        checks++;
        if ({bus.lt_valid, bus.at_valid, bus.err_valid, bus.at_is_rsp} != 4'b0 || bus.lt_lse != 8'h00 || bus.at_len != '0 || bus.at_data != '0 || bus.err_code != 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: lse=%h len=%0d code=%0d data=%h, required all zero", bus.lt_lse, bus.at_len, bus.err_code, bus.at_data);
        end
        rst = 1'b0;
        idle(5);

        // Directed LT with exact result latency
        send_lt(8'h83, 1'b0);
        repeat (2) @(negedge sb_clk);
        checks++;
        if (bus.lt_valid !== 1'b0) begin
            errors++;
            $display("FAIL lt_early: lt_valid=%0b two cycles after ETX stop, required 0", bus.lt_valid);
        end
        @(negedge sb_clk);
        checks++;
        if (bus.lt_valid !== 1'b1 || bus.lt_lse !== 8'h83) begin
            errors++;
            $display("FAIL lt_latency: lt_valid=%0b lse=%h three cycles after ETX stop, required 1/83", bus.lt_valid, bus.lt_lse);
        end
        idle(5);

        send_lt(8'h83, 1'b1);
        idle(5);

        pl = {};
        pl.push_back(8'h01); pl.push_back(8'h02);
        send_at(1'b0, pl, 1'b0);
        idle(5);
        checks++;
        if (bus.err_code !== ERR_CLSE) begin
            errors++;
            $display("FAIL err_code_hold: err_code=%0d after AT success, required %0d", bus.err_code, ERR_CLSE);
        end

        send_at(1'b0, pl, 1'b1);
        idle(5);

        pl = {};
        pl.push_back(8'h01); pl.push_back(8'hFE); pl.push_back(8'h02);
        send_at(1'b0, pl, 1'b0);
        idle(5);

        // Bad stop bit mid-AT, then line held low before returning idle
        expq.push_back(mk_err(ERR_FRAME));
        tx_byte(DLE, 1'b1);
        tx_byte(STX_CMD, 1'b1);
        tx_byte(8'h01, 1'b1);
        tx_byte(8'h02, 1'b0);
        repeat (20) @(negedge sb_clk) bus.sbrx = 1'b0;
        idle(30);

        expq.push_back(mk_err(ERR_OVF));
        tx_byte(DLE, 1'b1);
        tx_byte(STX_RSP, 1'b1);
        for (int i = 0; i < MAXB + 1; i++) tx_byte(8'(i + 16), 1'b1);
        idle(10);

        expq.push_back(mk_err(ERR_TMO));
        tx_byte(DLE, 1'b1);
        tx_byte(STX_CMD, 1'b1);
        idle(TMO + 6);

        // Reset mid-payload drops the partial frame
        tx_byte(DLE, 1'b1);
        tx_byte(STX_CMD, 1'b1);
        tx_byte(8'h11, 1'b1);
        @(negedge sb_clk) rst = 1'b1;
        @(negedge sb_clk);
        checks++;
        if (bus.err_code !== 3'd0 || bus.lt_lse !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: err_code=%0d lse=%h during reset, required 0/00", bus.err_code, bus.lt_lse);
        end
        rst = 1'b0;
        idle(5);
        send_lt(8'hA5, 1'b0);
        idle(5);

        // Enable dropped mid-AT: the rest of the frame is ignored
        tx_byte(DLE, 1'b1);
        tx_byte(STX_RSP, 1'b1);
        tx_byte(8'h21, 1'b1);
        @(negedge sb_clk) bus.sb_en = 1'b0;
        tx_byte(8'h22, 1'b1);
        tx_byte(8'h33, 1'b1);
        tx_byte(DLE, 1'b1);
        tx_byte(ETX, 1'b1);
        idle(5);
        bus.sb_en = 1'b1;
        idle(5);
        send_lt(8'hC3, 1'b0);
        idle(5);

        // Randomised traffic, gaps of 0..4 idle cycles
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: send_lt(8'($urandom_range(8'h80, 8'hFD)), 1'b0);
                1: send_lt(8'($urandom_range(8'h80, 8'hFD)), 1'b1);
                default: begin
                    pl = {};
                    for (int i = 0, len = $urandom_range(0, MAXB - 2); i < len; i++)
                        pl.push_back(($urandom_range(0, 3) == 0) ? DLE : 8'($urandom));
                    send_at(1'($urandom), pl, kind == 3);
                end
            endcase
            idle($urandom_range(0, 4));
        end

        idle(20);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_results: %0d expected results never seen, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
